// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
// Module      : timer_counter
// Description : Memory-mapped programmable 32-bit down-counter on the CPU
//               device bus. One-shot (mode 0) and auto-reload periodic
//               (mode 1) operation, with a maskable interrupt request.
//
//   Register map (word offset = Addr[3:2], Addr[1:0] ignored):
//     0 CTRL   R/W  [0] EN, [2:1] MODE, [3] IM (irq mask), [31:4] read 0
//     1 PRESET R/W  reload value
//     2 COUNT  RO   current count
//     3 -      reads 0
//
//   Ports:
//     clk    in   1   rising-edge clock
//     reset  in   1   synchronous, active-high
//     Addr   in   32  byte address
//     WD     in   32  write data
//     WE     in   1   write strobe (effective only on an address hit)
//     RD     out  32  combinational read data (0 when not hit)
//     IRQ    out  1   interrupt request = irq_flag & IM
//
// Revision    : 1.0  initial release
// ============================================================================
module timer_counter #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_7F00,
    parameter logic [31:0] RESET_PRESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic        IRQ
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_load = 2'd1;
    localparam logic [1:0] c_cnt  = 2'd2;
    localparam logic [1:0] c_int  = 2'd3;

    logic [1:0]  r_state;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic        w_hit;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_wr_cfg;
    logic [1:0]  w_state_nxt;
    logic [31:0] w_count_nxt;
    logic        w_flag_nxt;
    logic        w_en_nxt;
    logic [31:0] w_rd;
    logic        w_unused_addr;

    // Byte-lane bits play no role in register selection.
    assign w_unused_addr = ^Addr[1:0];

    assign w_hit       = (Addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr_ctrl   = WE && w_hit && (Addr[3:2] == 2'd0);
    assign w_wr_preset = WE && w_hit && (Addr[3:2] == 2'd1);
    assign w_wr_cfg    = w_wr_ctrl || w_wr_preset;

    // Next-state / next-value logic of the counting FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_flag_nxt  = r_irq_flag;
        w_en_nxt    = r_en;
        case (r_state)
            c_idle: begin
                if (r_en) begin
                    w_state_nxt = c_load;
                end
            end
            c_load: begin
                w_count_nxt = r_preset;
                w_state_nxt = c_cnt;
            end
            c_cnt: begin
                if (!r_en) begin
                    w_state_nxt = c_idle;
                end else if (r_count > 32'd1) begin
                    w_count_nxt = r_count - 32'd1;
                end else begin
                    // Covers a preset of 0 or 1 as well: never wrap below 0.
                    w_count_nxt = 32'd0;
                    w_flag_nxt  = 1'b1;
                    w_state_nxt = c_int;
                end
            end
            c_int: begin
                if (r_mode == 2'd1) begin
                    w_flag_nxt  = 1'b0;
                    w_state_nxt = c_load;
                end else begin
                    // Reserved modes 2/3 fall in here with one-shot mode.
                    w_en_nxt    = 1'b0;
                    w_state_nxt = c_idle;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // A CTRL/PRESET write overrides the FSM for that cycle: flag cleared,
    // FSM back to IDLE, COUNT untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_idle;
            r_en       <= 1'b0;
            r_mode     <= 2'd0;
            r_im       <= 1'b0;
            r_preset   <= RESET_PRESET;
            r_count    <= 32'd0;
            r_irq_flag <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en   <= WD[0];
                r_mode <= WD[2:1];
                r_im   <= WD[3];
            end else if (!w_wr_cfg) begin
                r_en <= w_en_nxt;
            end

            if (w_wr_preset) begin
                r_preset <= WD;
            end

            if (w_wr_cfg) begin
                r_irq_flag <= 1'b0;
                r_state    <= c_idle;
            end else begin
                r_irq_flag <= w_flag_nxt;
                r_state    <= w_state_nxt;
                r_count    <= w_count_nxt;
            end
        end
    end

    always_comb begin
        w_rd = 32'd0;
        if (w_hit) begin
            case (Addr[3:2])
                2'd0:    w_rd = {28'd0, r_im, r_mode, r_en};
                2'd1:    w_rd = r_preset;
                2'd2:    w_rd = r_count;
                default: w_rd = 32'd0;
            endcase
        end
    end

    assign RD  = w_rd;
    assign IRQ = r_irq_flag & r_im;

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_counter
// Description : Directed self-checking bench for timer_counter. Inputs are
//               driven and outputs sampled 1 ns (or more) after a rising
//               edge; each step is a hand-computed expectation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_timer_counter;

    localparam logic [31:0] c_ctrl   = 32'h0000_7F00;
    localparam logic [31:0] c_preset = 32'h0000_7F04;
    localparam logic [31:0] c_count  = 32'h0000_7F08;
    localparam logic [31:0] c_rsvd   = 32'h0000_7F0C;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    logic        IRQ;

    int n_pass;
    int n_total;

    timer_counter #(
        .BASE_ADDR    (32'h0000_7F00),
        .RESET_PRESET (32'd0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WD    (WD),
        .WE    (WE),
        .RD    (RD),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Addr = a;
        #1;
        chk(tag, RD, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        chk(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    // One bus write, landing on the next rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a;
        WD   = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        Addr    = 32'd0;
        WD      = 32'd0;
        WE      = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // 1: reset state
        rd("rst_ctrl",   c_ctrl,   32'd0);
        rd("rst_preset", c_preset, 32'd0);
        rd("rst_count",  c_count,  32'd0);
        rd("rst_rsvd",   c_rsvd,   32'd0);
        chk_irq("rst_irq", 1'b0);

        // 2: one-shot, PRESET=5, IM=1
        wr(c_preset, 32'd5);
        wr(c_ctrl, 32'h9);              // edge t
        tick();
        tick();                         // t+2
        for (int i = 0; i < 5; i++) begin
            rd("os_count", c_count, 32'(5 - i));
            chk_irq("os_irq_low", 1'b0);
            tick();
        end                             // t+7
        chk_irq("os_irq_rise", 1'b1);
        rd("os_count_zero", c_count, 32'd0);
        tick();                         // t+8
        rd("os_en_cleared", c_ctrl, 32'h8);
        chk_irq("os_irq_held1", 1'b1);
        tick();
        tick();
        chk_irq("os_irq_held2", 1'b1);
        wr(c_ctrl, 32'h8);
        chk_irq("os_irq_cleared", 1'b0);

        // 3: periodic, PRESET=3 -> IRQ every 5 cycles, 1 cycle wide
        wr(c_preset, 32'd3);
        wr(c_ctrl, 32'hB);              // edge t
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk_irq("per_irq", (k % 5) == 0);
            if ((k % 5) == 2) begin
                rd("per_reload", c_count, 32'd3);
            end
        end
        wr(c_ctrl, 32'h0);
        chk_irq("per_stop", 1'b0);
        rd("per_ctrl", c_ctrl, 32'd0);

        // 4: one-shot masked, PRESET=2
        wr(c_preset, 32'd2);
        wr(c_ctrl, 32'h1);              // edge t, flag sets at t+4
        for (int k = 0; k < 4; k++) tick();
        chk_irq("mask_irq_t4", 1'b0);
        tick();
        tick();
        chk_irq("mask_irq_t6", 1'b0);
        rd("mask_en_cleared", c_ctrl, 32'd0);
        rd("mask_count", c_count, 32'd0);
        wr(c_ctrl, 32'h8);              // unmask also clears the flag
        chk_irq("mask_unmask", 1'b0);
        rd("mask_ctrl", c_ctrl, 32'h8);

        // 5: pause mid-count and resume
        wr(c_preset, 32'd20);
        wr(c_ctrl, 32'h1);              // edge t, COUNT=20 at t+2, 7 at t+15
        for (int k = 0; k < 15; k++) tick();
        rd("pause_count7", c_count, 32'd7);
        wr(c_ctrl, 32'h0);
        rd("pause_hold_now", c_count, 32'd7);
        tick();
        tick();
        tick();
        rd("pause_hold_later", c_count, 32'd7);
        wr(c_ctrl, 32'h1);              // edge u
        rd("resume_u", c_count, 32'd7);
        tick();
        rd("resume_u1", c_count, 32'd7);
        tick();
        rd("resume_reload", c_count, 32'd20);
        wr(c_ctrl, 32'h0);
        rd("resume_stop", c_count, 32'd20);

        // 6: decode misses, read-only registers, WE gating, reset mid-run
        wr(32'h0000_7F10, 32'hFFFF_FFFF);
        rd("miss_preset", c_preset, 32'd20);
        rd("miss_rd_zero", 32'h0000_7F10, 32'd0);
        rd("miss_ctrl", c_ctrl, 32'd0);
        wr(c_count, 32'd5);
        rd("ro_count", c_count, 32'd20);
        wr(c_rsvd, 32'h0000_0123);
        rd("rsvd_zero", c_rsvd, 32'd0);
        wr(c_ctrl, 32'hFFFF_FFF0);
        rd("ctrl_upper", c_ctrl, 32'd0);
        Addr = c_preset;
        WD   = 32'd99;
        WE   = 1'b0;
        tick();
        rd("we_low", c_preset, 32'd20);

        wr(c_preset, 32'd1);
        wr(c_ctrl, 32'h9);              // edge t, flag at t+3
        tick();
        tick();
        tick();
        chk_irq("pre_reset_irq", 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_irq("post_reset_irq", 1'b0);
        rd("post_reset_ctrl",   c_ctrl,   32'd0);
        rd("post_reset_preset", c_preset, 32'd0);
        rd("post_reset_count",  c_count,  32'd0);
        tick();
        tick();
        chk_irq("post_reset_idle", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
